// File: rtl/prio_enc_8to3.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_8to3
// Description : Sequential priority encoder. Sticky pending capture of request
//               pulses, binary code of the winning line with valid/ack.
//               Define ROUND_ROBIN_EN for rotating priority (default: fixed,
//               lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_8to3 #(
    parameter int CODE_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [(1<<CODE_W)-1:0]   req_in,
    input  logic                     ack,
    output logic [CODE_W-1:0]        code,
    output logic                     valid,
    output logic [(1<<CODE_W)-1:0]   pending,
    output logic                     any_pend
);

    localparam int N_REQ = 1 << CODE_W;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_accept;
    logic [N_REQ-1:0]    r_pending;
    logic [N_REQ-1:0]    w_clr;
    logic [N_REQ-1:0]    w_pending_nxt;
    logic [CODE_W-1:0]   r_code;
    logic                r_valid;
    logic                r_any_pend;
    logic [CODE_W-1:0]   w_win;

`ifdef ROUND_ROBIN_EN
    logic [CODE_W-1:0]   r_rr_ptr;
    logic [CODE_W-1:0]   w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit after rr_ptr wins.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = r_rr_ptr + CODE_W'(k);
            if (r_pending[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= CODE_W'(N_REQ - 1);
        end else if (w_accept) begin
            r_rr_ptr <= r_code;
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_win = CODE_W'(i);
            end
        end
    end
`endif

    // Set wins over clear: a new pulse on the served bit re-pends it.
    always_comb begin
        w_accept      = r_valid & ack;
        w_clr         = w_accept ? (N_REQ'(1) << r_code) : '0;
        w_pending_nxt = (r_pending & ~w_clr) | (en ? req_in : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_code     <= '0;
            r_valid    <= 1'b0;
            r_any_pend <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_any_pend <= |w_pending_nxt;
            r_valid    <= (w_state_nxt == S_GRANT);
            if (w_load) begin
                r_code <= w_win;
            end
        end
    end

    assign code     = r_code;
    assign valid    = r_valid;
    assign pending  = r_pending;
    assign any_pend = r_any_pend;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_8to3.sv
`default_nettype none
// Testbench for prio_enc_8to3: expected grant codes queued at stimulus time,
// popped and compared when the DUT raises valid.
module tb_prio_enc_8to3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] req_in = '0;
    logic       ack = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       any_pend;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    prio_enc_8to3 dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .req_in   (req_in),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pending  (pending),
        .any_pend (any_pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; ack = 1'b0; en = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Bounded wait for valid, then compare code against the scoreboard head.
    task automatic wait_grant(input string name);
        int n;
        int exp;
        n = 0;
        while (valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: timeout waiting for valid (valid=%b)", name, valid);
        end else if ({29'd0, code} !== exp) begin
            errors++;
            $display("FAIL %s: code got %0d expected %0d", name, code, exp);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_in = 8'hFF; ack = 1'b0;
        step();
        step();
        rst = 1'b0; req_in = '0;
        checks++;
        if (valid !== 1'b0 || code !== 3'd0 || pending !== 8'h00 || any_pend !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b code=%0d pending=%h any_pend=%b expected 0/0/00/0",
                     valid, code, pending, any_pend);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (valid !== 1'b0 || pending !== 8'h00) begin
                errors++;
                $display("FAIL reset_no_grant: valid=%b pending=%h expected 0/00", valid, pending);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_in = 8'h20;
        exp_q.push_back(5);
        step();
        req_in = '0;
        checks++;
        if (pending !== 8'h20 || any_pend !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pend: pending=%h any_pend=%b valid=%b expected 20/1/0",
                     pending, any_pend, valid);
        end
        step();
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: valid=%b expected 1", valid);
        end
        wait_grant("single_code");
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (valid !== 1'b1 || code !== 3'd5) begin
                errors++;
                $display("FAIL single_hold: valid=%b code=%0d expected 1/5", valid, code);
            end
        end
        pulse_ack();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00 || any_pend !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: valid=%b pending=%h any_pend=%b expected 0/00/0",
                     valid, pending, any_pend);
        end
    endtask

    task automatic test_priority();
        do_reset();
        req_in = 8'h81;
        exp_q.push_back(0);
        exp_q.push_back(7);
        step();
        req_in = '0;
        wait_grant("prio_first");
        pulse_ack();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h80) begin
            errors++;
            $display("FAIL prio_gap: valid=%b pending=%h expected 0/80", valid, pending);
        end
        step();
        wait_grant("prio_second");
        pulse_ack();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_drain: pending=%h valid=%b expected 00/0", pending, valid);
        end
    endtask

    task automatic test_set_vs_clear();
        do_reset();
        req_in = 8'h08;
        exp_q.push_back(3);
        exp_q.push_back(3);
        step();
        req_in = '0;
        wait_grant("svc_first");
        ack = 1'b1; req_in = 8'h08;
        step();
        ack = 1'b0; req_in = '0;
        checks++;
        if (pending !== 8'h08 || valid !== 1'b0) begin
            errors++;
            $display("FAIL svc_repend: pending=%h valid=%b expected 08/0", pending, valid);
        end
        step();
        wait_grant("svc_regrant");
        pulse_ack();
        checks++;
        if (pending !== 8'h00) begin
            errors++;
            $display("FAIL svc_drain: pending=%h expected 00", pending);
        end
    endtask

    task automatic test_enable_abort();
        do_reset();
        en = 1'b0; req_in = 8'h0F;
        step();
        step();
        req_in = '0;
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL en_drop: pending=%h valid=%b expected 00/0", pending, valid);
        end
        en = 1'b1; req_in = 8'h02;
        exp_q.push_back(1);
        step();
        req_in = '0;
        wait_grant("abort_grant");
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00 || code !== 3'd0) begin
            errors++;
            $display("FAIL abort: valid=%b pending=%h code=%0d expected 0/00/0", valid, pending, code);
        end
        step();
        step();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: valid=%b expected 0", valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req_in = 8'h05;
        exp_q.push_back(0);
`ifdef ROUND_ROBIN_EN
        exp_q.push_back(2);
        exp_q.push_back(0);
`else
        exp_q.push_back(0);
        exp_q.push_back(2);
`endif
        step();
        req_in = '0;
        wait_grant("rot_first");
        ack = 1'b1; req_in = 8'h01;
        step();
        ack = 1'b0; req_in = '0;
        step();
        wait_grant("rot_second");
        pulse_ack();
        step();
        wait_grant("rot_third");
        pulse_ack();
        checks++;
        if (pending !== 8'h00 || valid !== 1'b0) begin
            errors++;
            $display("FAIL rot_drain: pending=%h valid=%b expected 00/0", pending, valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_set_vs_clear();
        test_enable_abort();
        test_rotation();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
